// File: rtl/key_repeat_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release
// pulses and auto-repeat with a long-hold indication.
module key_repeat_conditioner #(
  parameter int DB_CYCLES  = 500000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic long_hold
);

  localparam int MAX_AB = (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
  localparam int MAX_P  = (MAX_AB > RPT_PERIOD) ? MAX_AB : RPT_PERIOD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(RPT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] PRESS_DB   = 3'd1;
  localparam logic [2:0] HELD_WAIT  = 3'd2;
  localparam logic [2:0] HELD_RPT   = 3'd3;
  localparam logic [2:0] RELEASE_DB = 3'd4;

  logic          key_sync_p0;
  logic          ks;
  logic [2:0]    state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] rpt_cnt;
  logic [CW-1:0] rpt_last;

  // long_hold doubles as the "already past the initial delay" flag
  always_comb begin
    rpt_last = long_hold ? PERIOD_LAST : DELAY_LAST;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_sync_p0 <= 1'b0;
      ks          <= 1'b0;
      state       <= IDLE;
      db_cnt      <= '0;
      rpt_cnt     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      long_hold   <= 1'b0;
    end else begin
      // synchronizer stage boundary: key_in -> key_sync_p0 -> ks
      key_sync_p0 <= key_in;
      ks          <= key_sync_p0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      case (state)
        IDLE: begin
          if (ks) begin
            state  <= PRESS_DB;
            db_cnt <= CNT_ONE;
          end
        end
        PRESS_DB: begin
          if (!ks) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state      <= HELD_WAIT;
            db_cnt     <= '0;
            rpt_cnt    <= '0;
            key_level  <= 1'b1;
            key_press  <= 1'b1;
            key_repeat <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        HELD_WAIT, HELD_RPT: begin
          if (!ks) begin
            state  <= RELEASE_DB;
            db_cnt <= CNT_ONE;
          end else if (rpt_cnt == rpt_last) begin
            key_repeat <= 1'b1;
            rpt_cnt    <= '0;
            if (state == HELD_WAIT) begin
              long_hold <= 1'b1;
              state     <= HELD_RPT;
            end
          end else begin
            rpt_cnt <= rpt_cnt + CNT_ONE;
          end
        end
        RELEASE_DB: begin
          if (ks) begin
            state  <= long_hold ? HELD_RPT : HELD_WAIT;
            db_cnt <= '0;
            // the bounce-return edge is a held edge, so it still counts;
            // stopping at the terminal value defers that pulse one edge
            if (rpt_cnt != rpt_last) begin
              rpt_cnt <= rpt_cnt + CNT_ONE;
            end
          end else if (db_cnt == DB_LAST) begin
            state       <= IDLE;
            db_cnt      <= '0;
            rpt_cnt     <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
            long_hold   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
